mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port (Adr, WriteData, MemWrite, ReadData) of the micro-programmed RISC-V core between two requesters.
- Requester 0 is the core's multicycle fetch/load/store path. Requester 1 is the boot-loader/DMA engine.
- Arbitration is round-robin, with optional bus locking for bursts and a bounded hold time so neither side starves.
- The block sits between riscvuprog's memory interface and the memory, and stalls the core's controller via grant.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_HOLD, 8, maximum consecutive locked grants to one owner while the other requester waits (range 1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1  request valid; held with we/adr/wdata stable until granted
- we0, we1  in  1  1 = write, 0 = read
- lock0, lock1  in  1  keep ownership after this grant (burst)
- adr0, adr1  in  AW  byte address
- wdata0, wdata1  in  DW  write data
- gnt0, gnt1  out  1  transaction accepted this cycle (combinational)
- rvalid0, rvalid1  out  1  read data valid on rdata (registered)
- rdata  out  DW  broadcast of ReadData
- Adr  out  AW  memory address
- WriteData  out  DW  memory write data
- MemWrite  out  1  memory write strobe
- ReadData  in  DW  memory read data, valid one cycle after Adr (synchronous read)

Behaviour:
- Reset is synchronous and active-high.
  - state <= IDLE, last <= 1 (so requester 0 has first priority), hold_cnt <= 0, rvalid0/1 <= 0.
  - While reset = 1: gnt0 = gnt1 = 0 and MemWrite = 0. Adr and WriteData are don't-care but driven from requester 0.
- State register: one of IDLE, OWN0, OWN1. `last` records the most recent owner.
- Each cycle, combinational owner_next:
  - Locked case: if state = OWNk, reqk = 1, lockk held from the previous grant, and (other req = 0 or hold_cnt < MAX_HOLD), then owner_next = k.
  - Otherwise, round-robin: among asserted reqs, pick the one that is not `last`. If only one req is asserted, pick it. If none, owner_next = none.
- Outputs from owner_next:
  - gntk = (owner_next = k) and reqk.
  - Adr, WriteData and we are muxed from the owner. MemWrite = gnt and we of the owner.
  - With no owner: MemWrite = 0 and Adr holds the last owner's adr.
- Sequential update:
  - state <= OWNk if gntk and lockk, else IDLE.
  - last <= k on any gntk.
  - hold_cnt: increments (saturating at MAX_HOLD) when the locked owner is re-granted while the other requester is waiting. It resets to 0 on an ownership change or when state returns to IDLE.
- Reads: rvalidk <= gntk and not wek, so rdata is valid exactly one cycle after the grant.
- Writes complete in the grant cycle; there is no write response.
- Throughput: one transaction per cycle. A new grant may coincide with the previous read's rvalid cycle.
- The owner dropping req while locked releases the lock; state goes to IDLE the next cycle.
- Simultaneous req0 and req1 from IDLE with last = 1: grant 0. The following contested cycle grants 1.
- Reset asserted mid-read: the pending rvalid is dropped, with no response the cycle after reset.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined:
  - Adds outputs gnt_cnt0, gnt_cnt1 (32 bits each): wrapping counts of grants per requester.
  - Adds output starve_evt (16 bits): saturating count of forced lock breaks at MAX_HOLD.
  - All three are cleared by reset.
- When undefined: these ports and registers do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Package riscv_arb_pkg holds:
  - owner_t enum {IDLE, OWN0, OWN1}
  - constant NUM_REQ = 2
  - a req_t struct bundling req, we, lock, adr, wdata
- Sub-module rr_pick2 is the combinational two-way round-robin picker (inputs req[1:0] and last; output grant one-hot).
- Reuse the existing flopr for the rvalid registers.

Test Plan:
- Reset then idle: all req = 0 → gnt = 0, MemWrite = 0, rvalid = 0 for 10 cycles.
- Single read: req0 = 1, we0 = 0, adr0 = 0x100, memory returns 0xDEADBEEF → gnt0 in cycle 0; next cycle rvalid0 = 1, rdata = 0xDEADBEEF, rvalid1 = 0.
- Contention:
  - req0 and req1 held high, unlocked, from reset → grant order 0, 1, 0, 1.
  - Writes: adr0 = 0x10, adr1 = 0x20 → MemWrite pulses each cycle, alternating Adr.
- Lock and starvation, MAX_HOLD = 4:
  - Stimulus: req1 and lock1 held high; req0 asserted on cycle 2.
  - Response: gnt1 on cycles 0–5, gnt0 on cycle 6, then gnt1 again on cycle 7.
- Mid-operation reset: reset asserted the cycle after a read grant → rvalid0 = 0 the next cycle, state = IDLE, and req1 alone afterwards is granted immediately.
- With MEM_ARB_STATS_EN: 5 grants to requester 0 and 3 to requester 1 → gnt_cnt0 = 5, gnt_cnt1 = 3; one forced break → starve_evt = 1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter (riscvuprog core + boot/DMA).
// Optional statistics in the arbiter top are enabled with MEM_ARB_STATS_EN.
package riscv_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ARB_AW  = 32;
    localparam int unsigned ARB_DW  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic              lock;
        logic [ARB_AW-1:0] adr;
        logic [ARB_DW-1:0] wdata;
    } req_t;

    function automatic owner_t own_state(input logic idx);
        return idx ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter, master = requesters + memory.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req0, req1;
    logic          we0, we1;
    logic          lock0, lock1;
    logic [AW-1:0] adr0, adr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] Adr;
    logic [DW-1:0] WriteData;
    logic          MemWrite;
    logic [DW-1:0] ReadData;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, adr0, adr1, wdata0, wdata1, ReadData,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, Adr, WriteData, MemWrite
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, adr0, adr1, wdata0, wdata1, ReadData,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, Adr, WriteData, MemWrite
    );
endinterface

// File: rtl/flopr.sv
// Resettable register with synchronous active-high reset.
module flopr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end
endmodule

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on contention the requester that was not last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb begin
        grant = req;
        if (&req) grant = last ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the unified memory port with burst locking and bounded hold time.
// Define MEM_ARB_STATS_EN to add grant counters and a forced-lock-break counter.
module mem_port_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       gnt_cnt0,
    output logic [31:0]       gnt_cnt1,
    output logic [15:0]       starve_evt
`endif
);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    owner_t      state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  hold_q, hold_d;
    req_t        rq [NUM_REQ];
    logic [1:0]  req_v, rr_gnt, locked, sel, gnt;
    logic [1:0]  rvalid_d, rvalid_q;
    logic        own_idx;
    logic        continuing, other_wait;

    always_comb begin
        rq[0] = '{req: bus.req0, we: bus.we0, lock: bus.lock0,
                  adr: ARB_AW'(bus.adr0), wdata: ARB_DW'(bus.wdata0)};
        rq[1] = '{req: bus.req1, we: bus.we1, lock: bus.lock1,
                  adr: ARB_AW'(bus.adr1), wdata: ARB_DW'(bus.wdata1)};
        req_v = {rq[1].req, rq[0].req};
    end

    rr_pick2 u_pick (
        .req   (req_v),
        .last  (last_q),
        .grant (rr_gnt)
    );

    // A held lock wins unless the other side has waited MAX_HOLD grants.
    always_comb begin
        locked[0] = (state_q == own_state(1'b0)) && rq[0].req && (!rq[1].req || hold_q < HOLD_LIM);
        locked[1] = (state_q == own_state(1'b1)) && rq[1].req && (!rq[0].req || hold_q < HOLD_LIM);
        if (locked[0])      sel = 2'b01;
        else if (locked[1]) sel = 2'b10;
        else                sel = rr_gnt;
        gnt = reset ? 2'b00 : (sel & req_v);

        if (gnt[1])      own_idx = 1'b1;
        else if (gnt[0]) own_idx = 1'b0;
        else if (reset)  own_idx = 1'b0;
        else             own_idx = last_q;
    end

    assign bus.gnt0      = gnt[0];
    assign bus.gnt1      = gnt[1];
    assign bus.Adr       = rq[own_idx].adr[AW-1:0];
    assign bus.WriteData = rq[own_idx].wdata[DW-1:0];
    assign bus.MemWrite  = (|gnt) & rq[own_idx].we;
    assign bus.rdata     = bus.ReadData;
    assign bus.rvalid0   = rvalid_q[0];
    assign bus.rvalid1   = rvalid_q[1];

    always_comb begin
        state_d = IDLE;
        if (gnt[0] && rq[0].lock)      state_d = OWN0;
        else if (gnt[1] && rq[1].lock) state_d = OWN1;

        last_d = last_q;
        if (gnt[1])      last_d = 1'b1;
        else if (gnt[0]) last_d = 1'b0;

        continuing = (state_q == OWN0 && gnt[0]) || (state_q == OWN1 && gnt[1]);
        other_wait = (gnt[0] && rq[1].req) || (gnt[1] && rq[0].req);
        hold_d     = '0;
        if (state_d != IDLE && continuing)
            hold_d = (other_wait && hold_q < HOLD_LIM) ? hold_q + 8'd1 : hold_q;

        rvalid_d = {gnt[1] & ~rq[1].we, gnt[0] & ~rq[0].we};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    flopr #(.WIDTH(2)) u_rvalid (
        .clk   (clk),
        .reset (reset),
        .d     (rvalid_d),
        .q     (rvalid_q)
    );

`ifdef MEM_ARB_STATS_EN
    logic [31:0] gnt_cnt0_q, gnt_cnt1_q;
    logic [15:0] starve_q;
    logic        lock_break;

    always_comb begin
        lock_break = !reset &&
            ((state_q == OWN0 && rq[0].req && rq[1].req && hold_q >= HOLD_LIM) ||
             (state_q == OWN1 && rq[1].req && rq[0].req && hold_q >= HOLD_LIM));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
            starve_q   <= '0;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_q + {31'd0, gnt[0]};
            gnt_cnt1_q <= gnt_cnt1_q + {31'd0, gnt[1]};
            if (lock_break && starve_q != '1) starve_q <= starve_q + 16'd1;
        end
    end

    assign gnt_cnt0   = gnt_cnt0_q;
    assign gnt_cnt1   = gnt_cnt1_q;
    assign starve_evt = starve_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] gc0, gc1;
    logic [15:0] sev;
`endif

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .gnt_cnt0   (gc0),
        .gnt_cnt1   (gc1),
        .starve_evt (sev)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return (i == 64) ? 32'hDEADBEEF : (32'h9E3779B9 * i) ^ 32'h5A5A0000;
    endfunction

    // Synchronous-read memory model on the arbiter's memory side.
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        bus.ReadData = '0;
        forever begin
            @(posedge clk);
            bus.ReadData <= mem[bus.Adr[9:2]];
            if (bus.MemWrite) mem[bus.Adr[9:2]] <= bus.WriteData;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model state
    typedef struct { int due; logic [31:0] data; } exp_t;
    exp_t        q0[$], q1[$];
    logic [31:0] mem_ref [0:255];
    int m_last, m_lo, m_hold, m_breaks;
    int g_cnt [2];

    // Requester state
    logic        r_req [2], r_we [2], r_lock [2];
    logic [31:0] r_adr [2], r_wd [2];

    task automatic apply();
        bus.req0 = r_req[0];  bus.req1 = r_req[1];
        bus.we0 = r_we[0];    bus.we1 = r_we[1];
        bus.lock0 = r_lock[0]; bus.lock1 = r_lock[1];
        bus.adr0 = r_adr[0];  bus.adr1 = r_adr[1];
        bus.wdata0 = r_wd[0]; bus.wdata1 = r_wd[1];
    endtask

    task automatic set_req(input int k, input logic rq, input logic we, input logic lk,
                           input logic [31:0] adr, input logic [31:0] wd);
        r_req[k] = rq; r_we[k] = we; r_lock[k] = lk; r_adr[k] = adr; r_wd[k] = wd;
    endtask

    task automatic model_reset();
        m_last = 1; m_lo = -1; m_hold = 0; m_breaks = 0;
        g_cnt[0] = 0; g_cnt[1] = 0;
        q0.delete(); q1.delete();
    endtask

    // One clock cycle: drive, predict from the arbitration rules, compare combinational outputs.
    task automatic step(output int own, output logic [1:0] dg);
        int o, oth;
        exp_t e;
        apply();
        @(negedge clk);
        o  = -1;
        dg = {bus.gnt1, bus.gnt0};
        if (reset) begin
            check("rst_gnt", {30'd0, dg}, 32'd0);
            check("rst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
            model_reset();
        end else begin
            if (m_lo >= 0 && r_req[m_lo] && r_req[1-m_lo] && m_hold >= MH) m_breaks++;
            if (m_lo >= 0 && r_req[m_lo] && (!r_req[1-m_lo] || m_hold < MH)) o = m_lo;
            else if (r_req[0] && r_req[1]) o = 1 - m_last;
            else if (r_req[0]) o = 0;
            else if (r_req[1]) o = 1;
            check("gnt", {30'd0, dg}, (o == 1) ? 32'd2 : (o == 0) ? 32'd1 : 32'd0);
            if (o >= 0) begin
                oth = 1 - o;
                check("memwrite", {31'd0, bus.MemWrite}, {31'd0, r_we[o]});
                check("adr", bus.Adr, r_adr[o]);
                if (r_we[o]) begin
                    check("wdata", bus.WriteData, r_wd[o]);
                    mem_ref[r_adr[o][9:2]] = r_wd[o];
                end else begin
                    e.due = cyc + 1;
                    e.data = mem_ref[r_adr[o][9:2]];
                    if (o == 0) q0.push_back(e); else q1.push_back(e);
                end
                g_cnt[o]++;
                if (m_lo == o && r_lock[o]) begin
                    if (r_req[oth] && m_hold < MH) m_hold++;
                end else m_hold = 0;
                m_lo   = r_lock[o] ? o : -1;
                m_last = o;
            end else begin
                check("idle_memwrite", {31'd0, bus.MemWrite}, 32'd0);
                check("idle_adr", bus.Adr, r_adr[m_last]);
                m_lo = -1; m_hold = 0;
            end
        end
        own = o;
        @(posedge clk); #1;
    endtask

    // Read-response monitor, decoupled from stimulus.
    initial begin
        exp_t e;
        logic ex0, ex1;
        forever begin
            @(negedge clk); #2;
            if (!reset) begin
                ex0 = (q0.size() > 0) && (q0[0].due == cyc);
                ex1 = (q1.size() > 0) && (q1[0].due == cyc);
                check("rvalid0", {31'd0, bus.rvalid0}, {31'd0, ex0});
                check("rvalid1", {31'd0, bus.rvalid1}, {31'd0, ex1});
                if (ex0) begin
                    e = q0.pop_front();
                    if (bus.rvalid0) check("rdata0", bus.rdata, e.data);
                end
                if (ex1) begin
                    e = q1.pop_front();
                    if (bus.rvalid1) check("rdata1", bus.rdata, e.data);
                end
                if ((q0.size() > 0 && q0[0].due < cyc) || (q1.size() > 0 && q1[0].due < cyc)) begin
                    n_cmp++; n_err++;
                    $display("FAIL stale_read at cycle %0d: got no response expected one", cyc);
                    if (q0.size() > 0 && q0[0].due < cyc) void'(q0.pop_front());
                    if (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        int o; logic [1:0] dg;
        reset = 1'b1;
        step(o, dg);
        reset = 1'b0;
    endtask

    initial begin
        int o;
        logic [1:0] dg;
        logic [1:0] tbl_c [4];
        logic [1:0] tbl_s [8];
        tbl_c = '{2'b01, 2'b10, 2'b01, 2'b10};
        tbl_s = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 256; i++) mem_ref[i] = init_word(i);
        model_reset();

        // Reset with both requesters active: no grants, no write strobe.
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h1111);
        set_req(1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h2222);
        reset = 1'b1;
        repeat (3) step(o, dg);
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) step(o, dg);

        // Single read of 0x100 (preloaded with DEADBEEF).
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        step(o, dg);
        check("single_gnt0", {30'd0, dg}, 32'd1);
        r_req[0] = 1'b0;
        repeat (2) step(o, dg);

        // Unlocked write contention from reset: 0,1,0,1.
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h10, $urandom);
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h20, $urandom);
        for (int i = 0; i < 4; i++) begin
            step(o, dg);
            check("contend_order", {30'd0, dg}, {30'd0, tbl_c[i]});
            if (o >= 0) r_wd[o] = $urandom;
        end
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        step(o, dg);

        // Locked burst by requester 1, requester 0 arrives on cycle 2.
        do_reset();
        set_req(1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        set_req(0, 1'b0, 1'b1, 1'b0, 32'h80, 32'hCAFE0000);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) r_req[0] = 1'b1;
            step(o, dg);
            check("starve_order", {30'd0, dg}, {30'd0, tbl_s[i]});
        end
`ifdef MEM_ARB_STATS_EN
        check("starve_evt_directed", {16'd0, sev}, 32'd1);
`endif
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        repeat (2) step(o, dg);

        // Reset in the cycle after a read grant, then a lone request from 1.
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        step(o, dg);
        r_req[0] = 1'b0;
        reset = 1'b1;
        step(o, dg);
        reset = 1'b0;
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
        step(o, dg);
        check("post_reset_gnt1", {30'd0, dg}, 32'd2);
        r_req[1] = 1'b0;
        repeat (2) step(o, dg);

        // Randomized traffic; requests held until granted.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 599) == 0);
            step(o, dg);
            for (int k = 0; k < 2; k++) begin
                if (o == k || !r_req[k]) begin
                    set_req(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                            $urandom_range(0, 1) == 0, {22'd0, 8'($urandom), 2'b00}, $urandom);
                end
            end
        end
        reset = 1'b0;
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        repeat (3) step(o, dg);

`ifdef MEM_ARB_STATS_EN
        check("gnt_cnt0", gc0, 32'(g_cnt[0]));
        check("gnt_cnt1", gc1, 32'(g_cnt[1]));
        check("starve_evt", {16'd0, sev}, (m_breaks > 65535) ? 32'd65535 : 32'(m_breaks));
`endif
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
